// File: rtl/output_layer_sequencer.sv
// Output-layer inference window: collects NUM_STEPS timesteps of node outputs into
// saturating per-class accumulators, then resolves the winning class by serial argmax.
module output_layer_sequencer #(
  parameter int NUM_CLASSES = 4,
  parameter int NUM_STEPS   = 16,
  parameter int DATA_W      = 8,
  parameter int ACC_W       = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              i_start,
  input  logic                              i_abort,
  output logic                              o_step_req,
  input  logic                              i_step_valid,
  input  logic [NUM_CLASSES*DATA_W-1:0]     i_node_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [$clog2(NUM_CLASSES)-1:0]    o_class,
  output logic [ACC_W-1:0]                  o_score
);

  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam int IDX_W = $clog2(NUM_CLASSES + 1);
  localparam int CNT_W = $clog2(NUM_STEPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_ARGMAX,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q [NUM_CLASSES];
  logic [ACC_W-1:0] acc_d [NUM_CLASSES];
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CLS_W-1:0] best_idx_q, best_idx_d;
  logic [ACC_W-1:0] best_val_q, best_val_d;
  logic [CLS_W-1:0] class_q, class_d;
  logic [ACC_W-1:0] score_q, score_d;
  logic [CLS_W-1:0] cur_cls;

  assign cur_cls = idx_q[CLS_W-1:0];

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};
    return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    step_cnt_d = step_cnt_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    class_d    = class_q;
    score_d    = score_q;

    if (i_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) state_d = S_CLEAR;
        end
        S_CLEAR: begin
          for (int c = 0; c < NUM_CLASSES; c++) acc_d[c] = '0;
          step_cnt_d = '0;
          state_d    = S_COLLECT;
        end
        S_COLLECT: begin
          if (i_step_valid) begin
            for (int c = 0; c < NUM_CLASSES; c++)
              acc_d[c] = sat_add(acc_q[c], i_node_data[c*DATA_W +: DATA_W]);
            step_cnt_d = step_cnt_q + CNT_W'(1);
            if (step_cnt_q == CNT_W'(NUM_STEPS - 1)) begin
              idx_d      = '0;
              best_idx_d = '0;
              best_val_d = '0;
              state_d    = S_ARGMAX;
            end
          end
        end
        S_ARGMAX: begin
          // One compare per class, then one cycle to register the settled winner.
          if (idx_q == IDX_W'(NUM_CLASSES)) begin
            class_d = best_idx_q;
            score_d = best_val_q;
            state_d = S_DONE;
          end else begin
            if (acc_q[cur_cls] > best_val_q) begin
              best_val_d = acc_q[cur_cls];
              best_idx_d = cur_cls;
            end
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state updates use non-blocking assignments so all registers sample together.
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      // NOTE: the accumulator array is reset explicitly; it is a handful of flops, not a RAM.
      for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
      step_cnt_q <= '0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      class_q    <= '0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      step_cnt_q <= step_cnt_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      class_q    <= class_d;
      score_q    <= score_d;
    end
  end

  assign o_step_req = (state_q == S_COLLECT);
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);
  assign o_class    = class_q;
  assign o_score    = score_q;

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Bench for output_layer_sequencer: a default-width and an 8-bit-accumulator instance
// share stimulus; results are predicted from a saturating-sum / argmax reference model.
module tb_output_layer_sequencer;

  localparam int NC = 4;
  localparam int NS = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn, start, abort, valid;
  logic [NC*DW-1:0] data;

  logic          req_a, busy_a, done_a;
  logic [1:0]    cls_a;
  logic [15:0]   score_a;
  logic          req_b, busy_b, done_b;
  logic [1:0]    cls_b;
  logic [7:0]    score_b;

  int checks = 0;
  int errors = 0;
  logic [NC*DW-1:0] step_data [NS];
  int last_cls_a, last_sc_a, last_cls_b, last_sc_b;

  output_layer_sequencer #(.NUM_CLASSES(NC), .NUM_STEPS(NS), .DATA_W(DW), .ACC_W(16)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort),
    .o_step_req(req_a), .i_step_valid(valid), .i_node_data(data),
    .o_busy(busy_a), .o_done(done_a), .o_class(cls_a), .o_score(score_a)
  );

  output_layer_sequencer #(.NUM_CLASSES(NC), .NUM_STEPS(NS), .DATA_W(DW), .ACC_W(8)) dut8 (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort),
    .o_step_req(req_b), .i_step_valid(valid), .i_node_data(data),
    .o_busy(busy_b), .o_done(done_b), .o_class(cls_b), .o_score(score_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: per-class sums clamped to 2^accw-1 after every step, then first strict maximum.
  function automatic void model(input int accw, output int cls, output int score);
    longint acc [NC];
    longint maxv;
    maxv = (longint'(1) << accw) - 1;
    for (int c = 0; c < NC; c++) acc[c] = 0;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < NC; c++) begin
        acc[c] = acc[c] + longint'(step_data[s][c*DW +: DW]);
        if (acc[c] > maxv) acc[c] = maxv;
      end
    cls = 0;
    score = 0;
    for (int c = 0; c < NC; c++)
      if (acc[c] > longint'(score)) begin
        score = int'(acc[c]);
        cls = c;
      end
  endfunction

  task automatic fill_const(input logic [NC*DW-1:0] v);
    for (int s = 0; s < NS; s++) step_data[s] = v;
  endtask

  task automatic fill_random(input logic [NC*DW-1:0] mask);
    for (int s = 0; s < NS; s++) step_data[s] = $urandom & mask;
  endtask

  // gap_mode: 0 valid held high, 1 alternating, 2 random. pulse_start: extra starts in COLLECT/DONE.
  task automatic run_window(input string name, input int gap_mode, input bit pulse_start);
    int k = 0;
    int edges = 0;
    bit v;
    bit got = 0;
    int ea_c, ea_s, eb_c, eb_s;
    model(16, ea_c, ea_s);
    model(8, eb_c, eb_s);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_busy_after_start"}, busy_a, 1);
    for (int cyc = 0; cyc < 300 && !got; cyc++) begin
      v = 1'b0;
      if (req_a) begin
        case (gap_mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
      end
      valid = v;
      data  = v ? step_data[k] : NC*DW'($urandom);
      start = pulse_start && req_a && (k == 3);
      tick();
      edges++;
      if (v) k++;
      valid = 1'b0;
      start = 1'b0;
      check({name, "_step_req"}, req_a, (k < NS) ? 1 : 0);
      if (done_a) got = 1'b1;
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_steps_taken"}, k, NS);
    if (gap_mode == 0) check({name, "_latency"}, edges, 2 + NS + NC);
    check({name, "_done_b"}, done_b, 1);
    check({name, "_class"}, cls_a, ea_c);
    check({name, "_score"}, score_a, ea_s);
    check({name, "_class8"}, cls_b, eb_c);
    check({name, "_score8"}, score_b, eb_s);
    last_cls_a = ea_c; last_sc_a = ea_s;
    last_cls_b = eb_c; last_sc_b = eb_s;
    start = pulse_start;
    tick();
    start = 1'b0;
    check({name, "_done_one_cycle"}, done_a, 0);
    check({name, "_busy_low_after"}, busy_a, 0);
    tick();
    check({name, "_start_not_queued"}, busy_a, 0);
  endtask

  initial begin
    int done_count;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; valid = 1'b0; data = '0;
    tick();
    tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_req", req_a, 0);
    check("rst_class", cls_a, 0);
    check("rst_score", score_a, 0);
    rstn = 1'b1;
    tick();

    fill_const(32'h00_03_05_01);
    run_window("t1", 0, 1'b0);
    check("t1_const_class", cls_a, 1);
    check("t1_const_score", score_a, 80);

    fill_const(32'h01_07_07_02);
    run_window("t2_tie", 0, 1'b0);
    check("t2_const_score", score_a, 112);

    fill_const(32'hFF_FF_FF_FF);
    run_window("t3_sat", 0, 1'b0);
    check("t3_const_score8", score_b, 255);

    fill_random(32'h3F_3F_3F_3F);
    run_window("t4_toggle", 1, 1'b0);

    // Abort after five accumulations: straight to IDLE, previous result retained.
    fill_random('1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    for (int s = 0; s < 5; s++) begin
      valid = 1'b1; data = step_data[s]; tick();
    end
    abort = 1'b1; tick(); abort = 1'b0; valid = 1'b0;
    check("t5_abort_idle", busy_a, 0);
    check("t5_abort_keep_class", cls_a, last_cls_a);
    check("t5_abort_keep_score", score_a, last_sc_a);
    check("t5_abort_keep_score8", score_b, last_sc_b);
    done_count = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done_a) done_count++;
    end
    check("t5_abort_no_done", done_count, 0);

    // Reset during ARGMAX of a second run.
    start = 1'b1; tick(); start = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 40 && (i == 0 || req_a); i++) begin
      data = NC*DW'($urandom);
      tick();
    end
    valid = 1'b0;
    check("t5_in_argmax_req", req_a, 0);
    tick();
    tick();
    check("t5_in_argmax_busy", busy_a, 1);
    rstn = 1'b0; tick(); rstn = 1'b1;
    check("t5_rst_idle", busy_a, 0);
    check("t5_rst_done", done_a, 0);
    check("t5_rst_class", cls_a, 0);
    check("t5_rst_score", score_a, 0);
    check("t5_rst_score8", score_b, 0);
    done_count = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done_a) done_count++;
    end
    check("t5_rst_no_done", done_count, 0);

    fill_random(32'h0F_0F_0F_0F);
    run_window("t6_pulse", 2, 1'b1);
    fill_const(32'h02_00_01_00);
    run_window("t6_clean", 0, 1'b0);
    check("t6_clean_class", cls_a, 3);
    check("t6_clean_score", score_a, 32);

    for (int w = 0; w < 4; w++) begin
      fill_random((w % 2 == 0) ? 32'hFF_FF_FF_FF : 32'h1F_1F_1F_1F);
      run_window("rand", 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
